// File: rtl/store_narrow_unit_if.sv
// CPU store request, completion status and word-memory port of the store narrowing unit.
// master = CPU/memory side, slave = store_narrow_unit.
interface store_narrow_unit_if;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic        timeout;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    output start, size, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, misalign, timeout, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  start, size, addr, wdata, mem_rdata, mem_ready,
    output busy, done, misalign, timeout, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_narrow_unit.sv
// Narrows a register value to byte/half/word and merges it into word memory by read-modify-write.
// Latency with mem_ready=1: word 2, byte/half 3, fault 1 cycle; mem_ready stalls RD/WR up to WAIT_LIMIT cycles.
module store_narrow_unit #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  store_narrow_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_t      state, state_n;
  logic [31:0] addr_q, addr_n;
  logic [1:0]  size_q, size_n;
  logic [15:0] wdata_q, wdata_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic [31:0] merged_q, merged_n;
  logic        misalign_q, misalign_n;
  logic        timeout_q, timeout_n;
  logic        fault;
  logic [31:0] merged_rd;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      merged_q   <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      size_q     <= size_n;
      wdata_q    <= wdata_n;
      wait_cnt   <= wait_cnt_n;
      merged_q   <= merged_n;
      misalign_q <= misalign_n;
      timeout_q  <= timeout_n;
    end
  end

  always_comb begin
    fault = (bus.size == 2'b11) ||
            (bus.size == 2'b01 && bus.addr[0]) ||
            (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
  end

  // Only the addressed lane(s) take store data; the rest come from the word just read.
  always_comb begin
    merged_rd = bus.mem_rdata;
    if (size_q == 2'b00) begin
      merged_rd[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_rd[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    size_n     = size_q;
    wdata_n    = wdata_q;
    wait_cnt_n = wait_cnt;
    merged_n   = merged_q;
    misalign_n = misalign_q;
    timeout_n  = timeout_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          addr_n     = bus.addr;
          size_n     = bus.size;
          wdata_n    = bus.wdata[15:0];
          wait_cnt_n = '0;
          misalign_n = 1'b0;
          timeout_n  = 1'b0;
          if (fault) begin
            misalign_n = 1'b1;
            state_n    = S_DONE;
          end else if (bus.size == 2'b10) begin
            merged_n = bus.wdata;
            state_n  = S_WR;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_RD: begin
        if (bus.mem_ready) begin
          merged_n   = merged_rd;
          wait_cnt_n = '0;
          state_n    = S_WR;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      S_WR: begin
        if (bus.mem_ready) begin
          state_n = S_DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      S_DONE: begin
        misalign_n = 1'b0;
        timeout_n  = 1'b0;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Memory strobes decode from state alone, so mem_ready never reaches them combinationally.
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.mem_re    = (state == S_RD);
  assign bus.mem_we    = (state == S_WR);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = merged_q;
  assign bus.misalign  = misalign_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed stores against a handshaking memory model; a scoreboard queue holds the expected outcome of each store.
module tb_store_narrow_unit;

  logic CLK;
  logic Reset;
  int   vectors;
  int   miscompares;
  int   cyc;

  store_narrow_unit_if b();

  store_narrow_unit #(.WAIT_LIMIT(16)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (b.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mis;
    logic        to;
    int          wr;
    int          rd;
    logic        re_any;
    logic        we_any;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   pushed;
  int   done_cnt;

  // memory model state
  int   ready_delay;
  int   rcnt;
  logic [1:0] prev_req;

  // monitor state
  int          rd_cnt, wr_cnt;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic        re_any, we_any, overlap, prev_done;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: accepts each request after ready_delay wait cycles.
  always @(negedge CLK) begin
    logic [1:0] req;
    req = {b.mem_we, b.mem_re};
    if (req == 2'b00) begin
      rcnt = 0;
      b.mem_ready = 1'b0;
    end else begin
      if (req != prev_req) rcnt = 0;
      if (rcnt >= ready_delay) b.mem_ready = 1'b1;
      else begin
        b.mem_ready = 1'b0;
        rcnt++;
      end
    end
    prev_req = req;
  end

  always begin
    @(negedge CLK);
    #1;
    if (Reset) begin
      rd_cnt = 0; wr_cnt = 0; re_any = 0; we_any = 0; prev_done = 0;
    end else begin
      if (b.mem_re && b.mem_we) overlap = 1'b1;
      if (b.mem_re) re_any = 1'b1;
      if (b.mem_we) we_any = 1'b1;
      if (b.mem_re && b.mem_ready) begin rd_cnt++; rd_addr = b.mem_addr; end
      if (b.mem_we && b.mem_ready) begin wr_cnt++; wr_addr = b.mem_addr; wr_data = b.mem_wdata; end
      if (b.done) begin
        exp_t e;
        done_cnt++;
        chk("done_pulse_width", 32'(prev_done), 32'd0);
        chk("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("misalign", 32'(b.misalign), 32'(e.mis));
          chk("timeout", 32'(b.timeout), 32'(e.to));
          chk("writes", 32'(wr_cnt), 32'(e.wr));
          chk("reads", 32'(rd_cnt), 32'(e.rd));
          chk("re_seen", 32'(re_any), 32'(e.re_any));
          chk("we_seen", 32'(we_any), 32'(e.we_any));
          if (e.wr > 0) begin
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.wd);
          end
          if (e.rd > 0) chk("rd_addr", rd_addr, e.addr);
          if (e.lat >= 0) chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        end
        rd_cnt = 0; wr_cnt = 0; re_any = 0; we_any = 0;
      end
      prev_done = b.done;
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input logic [31:0] old, input int dly, input logic [31:0] exp_wd,
                          input logic mis, input logic to, input int lat, input bit extra);
    exp_t e;
    @(negedge CLK);
    ready_delay = dly;
    b.mem_rdata = old;
    b.addr  = a;
    b.size  = sz;
    b.wdata = wd;
    b.start = 1'b1;
    e.addr   = {a[31:2], 2'b00};
    e.wd     = exp_wd;
    e.mis    = mis;
    e.to     = to;
    e.wr     = (!mis && !to) ? 1 : 0;
    e.rd     = (!mis && !to && sz != 2'b10) ? 1 : 0;
    e.re_any = !mis && (sz != 2'b10);
    e.we_any = (!mis && !to);
    e.lat    = lat;
    e.start_cyc = cyc;
    sb.push_back(e);
    pushed++;
    @(negedge CLK);
    b.start = 1'b0;
    b.addr  = $urandom;
    b.wdata = $urandom;
    b.size  = 2'($urandom_range(0, 3));
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      #1;
      if (i == 1 && dly > 0) chk("busy_while_wait", 32'(b.busy), 32'd1);
      if (i == 1 && extra) begin
        b.addr  = 32'h0000_3000;
        b.size  = 2'b10;
        b.wdata = 32'hCAFE_F00D;
        b.start = 1'b1;
      end
      if (i == 2) b.start = 1'b0;
      if (!b.busy) break;
    end
    chk("idle_after_op", 32'(b.busy), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; pushed = 0; done_cnt = 0;
    ready_delay = 0; rcnt = 0; prev_req = 2'b00;
    rd_cnt = 0; wr_cnt = 0; re_any = 0; we_any = 0; overlap = 0; prev_done = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    Reset = 1'b1;
    b.start = 1'b0; b.size = 2'b00; b.addr = '0; b.wdata = '0;
    b.mem_rdata = '0; b.mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_flags", 32'({b.busy, b.done, b.misalign, b.timeout, b.mem_re, b.mem_we}), 32'd0);
    chk("reset_mem_addr", b.mem_addr, 32'd0);
    chk("reset_mem_wdata", b.mem_wdata, 32'd0);
    Reset = 1'b0;

    // byte, half and word stores with an always-ready memory
    do_store(32'h0000_1003, 2'b00, 32'hFFFF_FFAB, 32'h1122_3344, 0, 32'hAB22_3344, 0, 0, 3, 0);
    do_store(32'h0000_1001, 2'b00, 32'h0000_005A, 32'h1122_3344, 0, 32'h1122_5A44, 0, 0, 3, 0);
    do_store(32'h0000_1002, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 0, 32'hBEEF_3344, 0, 0, 3, 0);
    do_store(32'h0000_1000, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 0, 32'h1122_BEEF, 0, 0, 3, 0);
    do_store(32'h0000_2000, 2'b10, 32'hDEAD_BEEF, 32'h1122_3344, 0, 32'hDEAD_BEEF, 0, 0, 2, 0);

    // alignment and size faults
    do_store(32'h0000_2001, 2'b10, 32'h1234_5678, 32'h0, 0, 32'h0, 1, 0, 1, 0);
    do_store(32'h0000_2003, 2'b01, 32'h1234_5678, 32'h0, 0, 32'h0, 1, 0, 1, 0);
    do_store(32'h0000_2000, 2'b11, 32'h1234_5678, 32'h0, 0, 32'h0, 1, 0, 1, 0);

    // slow memory (3 wait cycles per request) plus an ignored start while busy
    do_store(32'h0000_1003, 2'b00, 32'h0000_00C3, 32'h1122_3344, 3, 32'hC322_3344, 0, 0, 9, 1);

    // memory never ready: read times out after WAIT_LIMIT cycles
    do_store(32'h0000_1002, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 255, 32'h0, 0, 1, 17, 0);

    // reset during WR aborts with no done pulse
    @(negedge CLK);
    ready_delay = 255;
    b.addr = 32'h0000_4000; b.size = 2'b10; b.wdata = 32'h5555_AAAA; b.start = 1'b1;
    @(negedge CLK);
    b.start = 1'b0;
    @(negedge CLK);
    #1;
    chk("we_before_reset", 32'(b.mem_we), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    #1;
    chk("abort_flags", 32'({b.busy, b.done, b.misalign, b.timeout, b.mem_re, b.mem_we}), 32'd0);
    chk("abort_mem_addr", b.mem_addr, 32'd0);
    chk("abort_mem_wdata", b.mem_wdata, 32'd0);
    Reset = 1'b0;
    ready_delay = 0;
    repeat (3) @(negedge CLK);

    // normal operation resumes after the abort
    do_store(32'h0000_1000, 2'b00, 32'h0000_0077, 32'h1122_3344, 0, 32'h1122_3377, 0, 0, 3, 0);

    #1;
    chk("done_count", 32'(done_cnt), 32'(pushed));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("re_we_exclusive", 32'(overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
